// File: rtl/mux_gate_pkg.sv
// Shared constants for the mux-built parity accumulator.
// Holds the FSM state encoding and the XOR/XNOR mode select values.
package mux_gate_pkg;

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_DROP  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic MODE_XOR  = 1'b0;
   localparam logic MODE_XNOR = 1'b1;

   typedef enum logic [1:0] {
      ACCUM = ST_ACCUM,
      DROP  = ST_DROP,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/mux_xor_vec.sv
// Combinational vector XOR (o_y = a ^ b) and conditional invert (o_yi = inv ? ~x : x).
// Both functions are built per bit from two_one_mux cells.
module mux_xor_vec #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_x,
   input  logic             i_inv,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_yi
);

   logic [WIDTH-1:0] w_nb;
   logic [WIDTH-1:0] w_nx;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      // Inverter is mux(1, 0, sel=b); XOR is mux(b, ~b, sel=a).
      two_one_mux u_inv_b (.i_d0(1'b1),   .i_d1(1'b0),     .i_sel(i_b[g]), .o_y(w_nb[g]));
      two_one_mux u_xor   (.i_d0(i_b[g]), .i_d1(w_nb[g]),  .i_sel(i_a[g]), .o_y(o_y[g]));
      two_one_mux u_inv_x (.i_d0(1'b1),   .i_d1(1'b0),     .i_sel(i_x[g]), .o_y(w_nx[g]));
      two_one_mux u_cinv  (.i_d0(i_x[g]), .i_d1(w_nx[g]),  .i_sel(i_inv),  .o_y(o_yi[g]));
   end

endmodule

// File: rtl/two_one_mux.sv
// Basic 2:1 mux cell. Every gate in the parity datapath is built from this cell.
module two_one_mux (
   input  logic i_d0,
   input  logic i_d1,
   input  logic i_sel,
   output logic o_y
);

   assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_parity_accum.sv
// Per-frame XOR/XNOR accumulator over a valid/ready word stream.
// Frames longer than MAX_LEN are flagged and their surplus words dropped.
module mux_parity_accum
   import mux_gate_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int MAX_LEN = 16,
   localparam int CW      = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_err
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_count;
   logic             r_err;
   logic             r_mode;

   logic [CW-1:0]    w_count_inc;
   logic             w_set_err;
   logic             w_out_inv;
   logic [WIDTH-1:0] w_acc_xor;
   logic [WIDTH-1:0] w_out_word;
   logic [WIDTH-1:0] w_unused_yi;
   logic [WIDTH-1:0] w_unused_y;

   assign w_count_inc = r_count + CW'(1);
   assign w_out_inv   = (r_mode == MODE_XNOR);

   mux_xor_vec #(.WIDTH(WIDTH)) u_acc_xor (
      .i_a   (r_acc),
      .i_b   (in_data),
      .i_x   ('0),
      .i_inv (1'b0),
      .o_y   (w_acc_xor),
      .o_yi  (w_unused_yi)
   );

   mux_xor_vec #(.WIDTH(WIDTH)) u_out_inv (
      .i_a   ('0),
      .i_b   ('0),
      .i_x   (r_acc),
      .i_inv (w_out_inv),
      .o_y   (w_unused_y),
      .o_yi  (w_out_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ACCUM;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block is given a default first, so no path can infer a latch.
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_set_err   = 1'b0;
      case (r_state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_last) begin
                  w_state_nxt = DONE;
               end else if (w_count_inc == CW'(MAX_LEN)) begin
                  w_set_err   = 1'b1;
                  w_state_nxt = DROP;
               end
            end
         end
         DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = ACCUM;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_mode  <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (in_valid) begin
                  if (r_count == '0) begin
                     r_acc  <= in_data;
                     r_mode <= mode;
                  end else begin
                     r_acc  <= w_acc_xor;
                  end
                  r_count <= w_count_inc;
                  if (w_set_err) r_err <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_acc   <= '0;
                  r_count <= '0;
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Result fields read as zero whenever no result is being offered.
   assign out_data  = out_valid ? w_out_word : '0;
   assign out_count = out_valid ? r_count    : '0;
   assign out_err   = out_valid & r_err;

endmodule

// File: doc/mux_parity_accum.md
# mux_parity_accum

Parametrised, registered successor to the team's mux-built XOR/XNOR gate. Accumulates the bitwise XOR (or XNOR) of a frame of WIDTH-bit words arriving over a valid/ready stream and presents one result word per frame on a valid/ready output. All XOR logic is built from the existing `two_one_mux` cell. The block sits between a word-stream source and a checker/consumer that needs per-frame parity.

## Interface
- `WIDTH`, default 8: data word width, at least 1.
- `MAX_LEN`, default 16: maximum words per frame, at least 1.
- `CW`, derived as `$clog2(MAX_LEN+1)`: width of the word counter. Local, not overridable.
- `clk`, input, 1 bit: single clock. Everything is rising-edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `in_valid`, input, 1 bit: an input word is offered.
- `in_ready`, output, 1 bit: the block accepts a word.
- `in_data`, input, WIDTH bits: input word.
- `in_last`, input, 1 bit: marks the final word of the frame. Qualified by `in_valid`.
- `mode`, input, 1 bit: 0 selects XOR, 1 selects XNOR. Sampled on the first accepted word of each frame.
- `out_valid`, output, 1 bit: a result is available.
- `out_ready`, input, 1 bit: the consumer takes the result.
- `out_data`, output, WIDTH bits: the frame result.
- `out_count`, output, CW bits: number of words accumulated, 1..MAX_LEN.
- `out_err`, output, 1 bit: the frame exceeded MAX_LEN words.

## Operation
- An input beat is accepted when `in_valid` and `in_ready` are both high.
- An output beat completes when `out_valid` and `out_ready` are both high.
- The FSM has three states: ACCUM, DROP and DONE.
- **ACCUM state**
  - `in_ready` = 1.
  - On an accepted beat:
    - If `count` = 0: `acc` <= `in_data` and `mode_q` <= `mode`.
    - Otherwise: `acc` <= `acc` XOR `in_data`.
    - `count` <= `count` + 1.
  - If `in_last` is high on the accepted beat, go to DONE.
  - Otherwise, if the beat makes `count` equal MAX_LEN, set `err_q` <= 1 and go to DROP.
- **DROP state**
  - `in_ready` = 1.
  - Accepted words are discarded. `acc` and `count` hold.
  - An accepted beat with `in_last` high goes to DONE.
- **DONE state**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_data` = `mode_q` ? ~`acc` : `acc`.
  - `out_count` = `count` and `out_err` = `err_q`.
  - On the output handshake: `acc`, `count` and `err_q` clear to 0 and the FSM returns to ACCUM.
- `out_data`, `out_count` and `out_err` are 0 whenever `out_valid` is 0.
- The XOR is built per bit from `two_one_mux`: inverter = mux(1, 0, b); xor = mux(b, ~b, a). The XNOR inversion uses the same mux inverter. No behavioural `^` or `~` operators on the datapath.
- Changes to `mode` mid-frame have no effect on the current frame.
- `in_data` and `in_last` are ignored when `in_valid` is low.

## Timing
- **Reset (`rst_n` low, asynchronous)**
  - State = ACCUM; `acc`, `count`, `err_q` and `mode_q` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0, `out_err` = 0, `in_ready` = 1.
- **Reset mid-frame:** the partial frame is discarded with no output. The next accepted word starts a new frame.
- **Latency:** `out_valid` rises on the clock edge that accepts the `in_last` beat, i.e. visible in the following cycle.
- **Backpressure:** while `out_valid` = 1 and `out_ready` = 0, all outputs hold stable and `in_ready` = 0.
- **After the output handshake:** `in_ready` = 1 in the next cycle. There is no input/output overlap, so throughput is one frame per (frame length + 1) cycles minimum.
- **Frame of exactly MAX_LEN words with `in_last` on the final word:** goes to DONE with `out_err` = 0.
- **Overflow:** `count` saturates at MAX_LEN and never wraps.
- **Single-word frame (`in_last` on the first beat):** `out_data` = `in_data`, or its inverse in XNOR mode, with `out_count` = 1.

## Structure
- Shared package `mux_gate_pkg` holds:
  - the state encoding localparams `ST_ACCUM` = 2'd0, `ST_DROP` = 2'd1, `ST_DONE` = 2'd2;
  - the `MODE_XOR` / `MODE_XNOR` constants.
- One sub-module, `mux_xor_vec #(WIDTH)`. It is combinational and provides:
  - a generate loop of `two_one_mux`-based XOR slices, output `y` = a XOR b;
  - a conditional-invert output `yi` = inv ? ~x : x, also mux-built.
  - The top level instantiates it twice: once for accumulation and once for the XNOR output stage.
- The top level contains the FSM, the registers and the handshake logic.

## Test plan
All scenarios use WIDTH=8 and MAX_LEN=4.
1. mode=0; frame 0x0F, 0xF0, 0x3C with `in_last` on 0x3C -> `out_data`=0xC3, `out_count`=3, `out_err`=0. `out_valid` is high in the cycle after the last beat.
2. The same frame with mode=1 on the first beat, and `mode` toggled on later beats -> `out_data`=0x3C.
3. Single word 0xA5 with `in_last`, mode=0 -> `out_data`=0xA5, `out_count`=1.
4. Words 0x01..0x06 with `in_last` on 0x06 -> `in_ready` stays 1 through the dropped beats; result `out_data`=0x04, `out_count`=4, `out_err`=1. Separately, exactly 4 words with `in_last` on the 4th -> `out_err`=0.
5. `out_ready` held low for 5 cycles after `out_valid` rises -> outputs stable and `in_ready`=0 throughout. After the handshake, `in_ready`=1 in the next cycle and a new frame 0x11 (last) yields 0x11.
6. Assert `rst_n` low after 2 accepted words -> `out_valid`=0 and counters cleared immediately. Then frame 0x55 (last) -> `out_data`=0x55, `out_count`=1.
